// File: rtl/mips_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_pkg : opcode/funct constants, ALU op encoding and ID/EX record type.
// Rev 1.0
// ---------------------------------------------------------------------------
package mips_pkg;

   localparam logic [31:0] NO_REDIRECT = 32'hffff_ffff;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_SLT   = 6'h2a;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_OR   = 3'd2,
      ALU_SLT  = 3'd3,
      ALU_LUI  = 3'd4,
      ALU_LINK = 3'd5
   } alu_op_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm_ext;
      logic [4:0]  rs;
      logic [4:0]  rt;
      alu_op_e     alu_op;
      logic        alu_src;
      logic        mem_read;
      logic        mem_write;
      logic        wreg;
      logic [4:0]  waddr;
   } idex_t;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   // True when a nonzero producer address matches a source the instruction reads.
   function automatic logic src_hit(input logic [4:0] a, input logic [4:0] rs, input logic [4:0] rt,
                                    input logic uses_rs, input logic uses_rt);
      return (a != 5'd0) && ((uses_rs && (a == rs)) || (uses_rt && (a == rt)));
   endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile : 32x32 register file, 2 read / 1 write, write-through, $0 hardwired.
// Rev 1.0
// ---------------------------------------------------------------------------
module regfile
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  raddr1_i,
   output logic [31:0] rdata1_o,
   input  logic [4:0]  raddr2_i,
   output logic [31:0] rdata2_o,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i
);

   logic [31:0] mem_q [32];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) mem_q[i] <= '0;
      end else if (we_i && (waddr_i != 5'd0)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 :
                     (we_i && (waddr_i == raddr1_i)) ? wdata_i : mem_q[raddr1_i];
   assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 :
                     (we_i && (waddr_i == raddr2_i)) ? wdata_i : mem_q[raddr2_i];

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// id_stage : IF/ID latch, register read, decode, in-ID branch resolution and
//            hazard detection; registers the decoded instruction into ID/EX.
// Rev 1.0
// ---------------------------------------------------------------------------
module id_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] NO_REDIRECT = mips_pkg::NO_REDIRECT
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_inst,
   input  logic [31:0] if_pc,
   input  logic [31:0] if_pc_plus4,
   input  logic        ex_wreg,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_waddr,
   input  logic        mem_wreg,
   input  logic        mem_mem_read,
   input  logic [4:0]  mem_waddr,
   input  logic [31:0] mem_result,
   input  logic        wb_we,
   input  logic [4:0]  wb_waddr,
   input  logic [31:0] wb_wdata,
   output logic [31:0] npc,
   output logic        pc_stall_en,
   output logic        Flush,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_rs_data,
   output logic [31:0] id_rt_data,
   output logic [31:0] id_imm_ext,
   output logic [4:0]  id_rs,
   output logic [4:0]  id_rt,
   output logic [2:0]  id_alu_op,
   output logic        id_alu_src,
   output logic        id_mem_read,
   output logic        id_mem_write,
   output logic        id_wreg,
   output logic [4:0]  id_waddr
);

   logic [31:0] ifid_inst_q, ifid_pc_q, ifid_pc4_q;
   idex_t       idex_q, idex_d, dec;

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm16;

   assign opcode = ifid_inst_q[31:26];
   assign rs     = ifid_inst_q[25:21];
   assign rt     = ifid_inst_q[20:16];
   assign rd     = ifid_inst_q[15:11];
   assign funct  = ifid_inst_q[5:0];
   assign imm16  = ifid_inst_q[15:0];

   logic [31:0] rs_rf, rt_rf, rs_fwd, rt_fwd;

   regfile u_regfile (
      .clk      (clk),
      .rst      (rst),
      .raddr1_i (rs),
      .rdata1_o (rs_rf),
      .raddr2_i (rt),
      .rdata2_o (rt_rf),
      .we_i     (wb_we),
      .waddr_i  (wb_waddr),
      .wdata_i  (wb_wdata)
   );

   // A non-load MEM result beats write-through and the array (both inside rs_rf/rt_rf).
   logic mem_fwd_ok;
   assign mem_fwd_ok = mem_wreg && !mem_mem_read && (mem_waddr != 5'd0);
   assign rs_fwd     = (mem_fwd_ok && (mem_waddr == rs)) ? mem_result : rs_rf;
   assign rt_fwd     = (mem_fwd_ok && (mem_waddr == rt)) ? mem_result : rt_rf;

   logic known, uses_rs, uses_rt, is_beq, is_bne, is_jump, is_jr;

   always_comb begin
      dec     = '0;
      known   = 1'b1;
      uses_rs = 1'b0;
      uses_rt = 1'b0;
      is_beq  = 1'b0;
      is_bne  = 1'b0;
      is_jump = 1'b0;
      is_jr   = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: begin dec.alu_op = ALU_ADD; dec.wreg = 1'b1; dec.waddr = rd; uses_rs = 1'b1; uses_rt = 1'b1; end
               FN_SUBU: begin dec.alu_op = ALU_SUB; dec.wreg = 1'b1; dec.waddr = rd; uses_rs = 1'b1; uses_rt = 1'b1; end
               FN_SLT:  begin dec.alu_op = ALU_SLT; dec.wreg = 1'b1; dec.waddr = rd; uses_rs = 1'b1; uses_rt = 1'b1; end
               FN_JR:   begin is_jr = 1'b1; uses_rs = 1'b1; end
               default: known = 1'b0;
            endcase
         end
         OP_ORI: begin
            dec.alu_op = ALU_OR; dec.alu_src = 1'b1; dec.wreg = 1'b1; dec.waddr = rt;
            dec.imm_ext = {16'd0, imm16}; uses_rs = 1'b1;
         end
         OP_LUI: begin
            dec.alu_op = ALU_LUI; dec.alu_src = 1'b1; dec.wreg = 1'b1; dec.waddr = rt;
            dec.imm_ext = {imm16, 16'd0};
         end
         OP_LW: begin
            dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.wreg = 1'b1;
            dec.waddr = rt; dec.imm_ext = sext16(imm16); uses_rs = 1'b1;
         end
         OP_SW: begin
            dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.mem_write = 1'b1;
            dec.imm_ext = sext16(imm16); uses_rs = 1'b1; uses_rt = 1'b1;
         end
         OP_BEQ: begin dec.imm_ext = sext16(imm16); is_beq = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
         OP_BNE: begin dec.imm_ext = sext16(imm16); is_bne = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
         OP_J:   is_jump = 1'b1;
         OP_JAL: begin
            // No delay slot: the link value is the jal's own PC+4.
            dec.alu_op = ALU_LINK; dec.wreg = 1'b1; dec.waddr = 5'd31;
            dec.imm_ext = ifid_pc4_q; is_jump = 1'b1;
         end
         default: known = 1'b0;
      endcase
      dec.valid = 1'b1;
      dec.pc    = ifid_pc_q;
      if (known) begin
         dec.rs      = rs;
         dec.rt      = rt;
         dec.rs_data = rs_rf;
         dec.rt_data = rt_rf;
      end
   end

   logic ex_hit, mem_hit, load_use, ctl_hazard, stall, taken;
   logic [31:0] target, br_off;

   assign ex_hit     = src_hit(ex_waddr, rs, rt, uses_rs, uses_rt);
   assign mem_hit    = src_hit(mem_waddr, rs, rt, uses_rs, uses_rt);
   assign load_use   = ex_mem_read && ex_hit;
   assign ctl_hazard = (is_beq || is_bne || is_jr) && ((ex_wreg && ex_hit) || (mem_mem_read && mem_hit));
   assign stall      = !rst && (load_use || ctl_hazard);
   assign br_off     = {{14{imm16[15]}}, imm16, 2'b00};

   always_comb begin
      taken  = 1'b0;
      target = ifid_pc4_q + br_off;
      if (is_beq) taken = (rs_fwd == rt_fwd);
      if (is_bne) taken = (rs_fwd != rt_fwd);
      if (is_jump) begin
         taken  = 1'b1;
         target = {ifid_pc4_q[31:28], ifid_inst_q[25:0], 2'b00};
      end
      if (is_jr) begin
         taken  = 1'b1;
         target = rs_fwd;
      end
   end

   assign pc_stall_en = stall;
   assign Flush       = !rst && !stall && taken;
   assign npc         = Flush ? target : NO_REDIRECT;
   assign idex_d      = stall ? '0 : dec;

   always_ff @(posedge clk) begin
      if (rst) begin
         ifid_inst_q <= '0;
         ifid_pc_q   <= '0;
         ifid_pc4_q  <= '0;
      end else if (!stall) begin
         ifid_inst_q <= if_inst;
         ifid_pc_q   <= if_pc;
         ifid_pc4_q  <= if_pc_plus4;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) idex_q <= '0;
      else     idex_q <= idex_d;
   end

   assign id_valid     = idex_q.valid;
   assign id_pc        = idex_q.pc;
   assign id_rs_data   = idex_q.rs_data;
   assign id_rt_data   = idex_q.rt_data;
   assign id_imm_ext   = idex_q.imm_ext;
   assign id_rs        = idex_q.rs;
   assign id_rt        = idex_q.rt;
   assign id_alu_op    = idex_q.alu_op;
   assign id_alu_src   = idex_q.alu_src;
   assign id_mem_read  = idex_q.mem_read;
   assign id_mem_write = idex_q.mem_write;
   assign id_wreg      = idex_q.wreg;
   assign id_waddr     = idex_q.waddr;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_id_stage : directed scenarios plus randomized traffic against a
//               mnemonic-level reference model of the decode stage.
// ---------------------------------------------------------------------------
module tb_id_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] if_inst, if_pc, if_pc_plus4;
   logic        ex_wreg, ex_mem_read, mem_wreg, mem_mem_read, wb_we;
   logic [4:0]  ex_waddr, mem_waddr, wb_waddr;
   logic [31:0] mem_result, wb_wdata;

   logic [31:0] npc, id_pc, id_rs_data, id_rt_data, id_imm_ext;
   logic        pc_stall_en, Flush, id_valid, id_alu_src, id_mem_read, id_mem_write, id_wreg;
   logic [4:0]  id_rs, id_rt, id_waddr;
   logic [2:0]  id_alu_op;

   id_stage #(.NO_REDIRECT(32'hffff_ffff)) dut (
      .clk(clk), .rst(rst), .if_inst(if_inst), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
      .ex_wreg(ex_wreg), .ex_mem_read(ex_mem_read), .ex_waddr(ex_waddr),
      .mem_wreg(mem_wreg), .mem_mem_read(mem_mem_read), .mem_waddr(mem_waddr), .mem_result(mem_result),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .npc(npc), .pc_stall_en(pc_stall_en), .Flush(Flush),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm_ext(id_imm_ext), .id_rs(id_rs), .id_rt(id_rt), .id_alu_op(id_alu_op),
      .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_wreg(id_wreg), .id_waddr(id_waddr)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_NOP, M_ADDU, M_SUBU, M_SLT, M_ORI, M_LUI, M_LW, M_SW,
                 M_BEQ, M_BNE, M_J, M_JAL, M_JR} mn_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rs_data, rt_data, imm;
      logic [4:0]  rs, rt;
      logic [2:0]  op;
      logic        src, mr, mw, wreg;
      logic [4:0]  waddr;
   } exp_t;

   logic [31:0] m_rf [32];
   logic [31:0] m_inst, m_pc, m_pc4, m_npc;
   logic        m_stall, m_flush;
   exp_t        m_id;

   function automatic mn_t classify(input logic [31:0] i);
      mn_t m = M_NOP;
      case (i[31:26])
         6'h00: case (i[5:0])
                   6'h21: m = M_ADDU;
                   6'h23: m = M_SUBU;
                   6'h2a: m = M_SLT;
                   6'h08: m = M_JR;
                   default: m = M_NOP;
                endcase
         6'h0d: m = M_ORI;
         6'h0f: m = M_LUI;
         6'h23: m = M_LW;
         6'h2b: m = M_SW;
         6'h04: m = M_BEQ;
         6'h05: m = M_BNE;
         6'h02: m = M_J;
         6'h03: m = M_JAL;
         default: m = M_NOP;
      endcase
      return m;
   endfunction

   function automatic bit reads_rs(input mn_t m);
      return m inside {M_ADDU, M_SUBU, M_SLT, M_ORI, M_LW, M_SW, M_BEQ, M_BNE, M_JR};
   endfunction

   function automatic bit reads_rt(input mn_t m);
      return m inside {M_ADDU, M_SUBU, M_SLT, M_SW, M_BEQ, M_BNE};
   endfunction

   function automatic bit hits(input logic [4:0] a, input mn_t m, input logic [4:0] s, input logic [4:0] t);
      return (a != 5'd0) && ((reads_rs(m) && a == s) || (reads_rt(m) && a == t));
   endfunction

   function automatic logic [31:0] rf_read(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (wb_we && wb_waddr == r) return wb_wdata;
      return m_rf[r];
   endfunction

   function automatic logic [31:0] fwd(input logic [4:0] r);
      if (r != 5'd0 && mem_wreg && !mem_mem_read && mem_waddr == r) return mem_result;
      return rf_read(r);
   endfunction

   task automatic model_comb();
      mn_t m;
      logic [4:0] s, t;
      logic [31:0] tgt, boff;
      bit redir, lu, bh;
      m = classify(m_inst);
      s = m_inst[25:21];
      t = m_inst[20:16];
      lu = ex_mem_read && hits(ex_waddr, m, s, t);
      bh = (m inside {M_BEQ, M_BNE, M_JR}) &&
           ((ex_wreg && hits(ex_waddr, m, s, t)) || (mem_mem_read && hits(mem_waddr, m, s, t)));
      m_stall = !rst && (lu || bh);
      boff = {{16{m_inst[15]}}, m_inst[15:0]} * 4;
      redir = 1'b0;
      tgt = 32'd0;
      case (m)
         M_BEQ: begin redir = (fwd(s) == fwd(t)); tgt = m_pc4 + boff; end
         M_BNE: begin redir = (fwd(s) != fwd(t)); tgt = m_pc4 + boff; end
         M_J, M_JAL: begin redir = 1'b1; tgt = (m_pc4 & 32'hf000_0000) | ({6'd0, m_inst[25:0]} * 4); end
         M_JR: begin redir = 1'b1; tgt = fwd(s); end
         default: redir = 1'b0;
      endcase
      m_flush = !rst && !m_stall && redir;
      m_npc = m_flush ? tgt : 32'hffff_ffff;
   endtask

   function automatic exp_t model_decode();
      exp_t e = '0;
      mn_t m = classify(m_inst);
      logic [15:0] im = m_inst[15:0];
      e.valid = 1'b1;
      e.pc = m_pc;
      if (m != M_NOP) begin
         e.rs = m_inst[25:21];
         e.rt = m_inst[20:16];
         e.rs_data = rf_read(m_inst[25:21]);
         e.rt_data = rf_read(m_inst[20:16]);
      end
      case (m)
         M_ADDU: begin e.op = 3'd0; e.wreg = 1; e.waddr = m_inst[15:11]; end
         M_SUBU: begin e.op = 3'd1; e.wreg = 1; e.waddr = m_inst[15:11]; end
         M_SLT:  begin e.op = 3'd3; e.wreg = 1; e.waddr = m_inst[15:11]; end
         M_ORI:  begin e.op = 3'd2; e.src = 1; e.wreg = 1; e.waddr = m_inst[20:16]; e.imm = 32'(im); end
         M_LUI:  begin e.op = 3'd4; e.src = 1; e.wreg = 1; e.waddr = m_inst[20:16]; e.imm = 32'(im) << 16; end
         M_LW:   begin e.src = 1; e.mr = 1; e.wreg = 1; e.waddr = m_inst[20:16]; e.imm = 32'($signed(im)); end
         M_SW:   begin e.src = 1; e.mw = 1; e.imm = 32'($signed(im)); end
         M_BEQ, M_BNE: e.imm = 32'($signed(im));
         M_JAL:  begin e.op = 3'd5; e.wreg = 1; e.waddr = 5'd31; e.imm = m_pc4; end
         default: ;
      endcase
      return e;
   endfunction

   // One clock: inputs already driven after the falling edge.
   task automatic step();
      exp_t nxt;
      model_comb();
      if (m_flush) if_inst = 32'd0;
      #1;
      check_val("npc", npc, m_npc);
      check_val("flush", Flush, m_flush);
      check_val("stall", pc_stall_en, m_stall);
      nxt = (rst || m_stall) ? exp_t'('0) : model_decode();
      @(posedge clk);
      #1;
      m_id = nxt;
      if (rst) begin
         m_inst = 0; m_pc = 0; m_pc4 = 0;
         for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      end else begin
         if (!m_stall) begin m_inst = if_inst; m_pc = if_pc; m_pc4 = if_pc_plus4; end
         if (wb_we && wb_waddr != 5'd0) m_rf[wb_waddr] = wb_wdata;
      end
      check_val("id_valid", id_valid, m_id.valid);
      check_val("id_pc", id_pc, m_id.pc);
      check_val("id_rs_data", id_rs_data, m_id.rs_data);
      check_val("id_rt_data", id_rt_data, m_id.rt_data);
      check_val("id_imm_ext", id_imm_ext, m_id.imm);
      check_val("id_rs", id_rs, m_id.rs);
      check_val("id_rt", id_rt, m_id.rt);
      check_val("id_alu_op", id_alu_op, m_id.op);
      check_val("id_alu_src", id_alu_src, m_id.src);
      check_val("id_mem_read", id_mem_read, m_id.mr);
      check_val("id_mem_write", id_mem_write, m_id.mw);
      check_val("id_wreg", id_wreg, m_id.wreg);
      check_val("id_waddr", id_waddr, m_id.waddr);
   endtask

   // ---------------- stimulus helpers ----------------
   function automatic logic [31:0] r_type(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
      return {6'h00, s, t, d, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
      return {op, s, t, im};
   endfunction

   task automatic idle_inputs();
      rst = 0; if_inst = 0; if_pc = 32'h0000_1000; if_pc_plus4 = 32'h0000_1004;
      ex_wreg = 0; ex_mem_read = 0; ex_waddr = 0;
      mem_wreg = 0; mem_mem_read = 0; mem_waddr = 0; mem_result = 0;
      wb_we = 0; wb_waddr = 0; wb_wdata = 0;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [4:0] a, b, c;
      logic [15:0] im;
      logic [31:0] r;
      a = 5'($urandom_range(0, 7));
      b = 5'($urandom_range(0, 7));
      c = 5'($urandom_range(0, 7));
      im = 16'($urandom);
      r = $urandom;
      case ($urandom_range(0, 12))
         0: return r_type(6'h21, a, b, c);
         1: return r_type(6'h23, a, b, c);
         2: return r_type(6'h2a, a, b, c);
         3: return i_type(6'h0d, a, b, im);
         4: return i_type(6'h0f, 5'd0, b, im);
         5: return i_type(6'h23, a, b, im);
         6: return i_type(6'h2b, a, b, im);
         7: return i_type(6'h04, a, b, im);
         8: return i_type(6'h05, a, b, im);
         9: return {6'h02, r[25:0]};
         10: return {6'h03, r[25:0]};
         11: return r_type(6'h08, a, 5'd0, 5'd0);
         default: return r;
      endcase
   endfunction

   task automatic random_inputs();
      logic [31:0] p;
      rst = ($urandom_range(0, 63) == 0);
      if_inst = rand_inst();
      p = $urandom;
      if_pc = {p[31:2], 2'b00};
      if_pc_plus4 = if_pc + 32'd4;
      ex_wreg = 1'($urandom_range(0, 1));
      ex_mem_read = ex_wreg && ($urandom_range(0, 2) == 0);
      ex_waddr = 5'($urandom_range(0, 7));
      mem_wreg = 1'($urandom_range(0, 1));
      mem_mem_read = mem_wreg && ($urandom_range(0, 2) == 0);
      mem_waddr = 5'($urandom_range(0, 7));
      mem_result = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
      wb_we = 1'($urandom_range(0, 1));
      wb_waddr = 5'($urandom_range(0, 7));
      wb_wdata = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
   endtask

   initial begin
      m_inst = 0; m_pc = 0; m_pc4 = 0; m_id = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      idle_inputs();
      rst = 1;

      // Reset held for two cycles.
      repeat (2) begin
         @(negedge clk); idle_inputs(); rst = 1; step();
      end
      check_val("rst_npc", npc, 32'hffff_ffff);
      check_val("rst_id_valid", id_valid, 1'b0);

      // Write-through, then a write to $0 that must be ignored.
      @(negedge clk); idle_inputs(); if_inst = r_type(6'h21, 5'd5, 5'd0, 5'd3); if_pc = 32'h200; if_pc_plus4 = 32'h204; step();
      @(negedge clk); idle_inputs(); if_inst = r_type(6'h21, 5'd0, 5'd0, 5'd3);
      wb_we = 1; wb_waddr = 5'd5; wb_wdata = 32'h1234; step();
      check_val("wt_rs_data", id_rs_data, 32'h1234);
      @(negedge clk); idle_inputs(); wb_we = 1; wb_waddr = 5'd0; wb_wdata = 32'hdead_beef; step();
      check_val("wt_zero_rs", id_rs_data, 32'd0);

      // Load-use.
      @(negedge clk); idle_inputs(); if_inst = r_type(6'h21, 5'd2, 5'd3, 5'd4); step();
      @(negedge clk); idle_inputs(); ex_wreg = 1; ex_mem_read = 1; ex_waddr = 5'd2;
      #1 check_val("lu_stall", pc_stall_en, 1'b1);
      step();
      check_val("lu_bubble", id_valid, 1'b0);
      @(negedge clk); idle_inputs();
      #1 check_val("lu_release", pc_stall_en, 1'b0);
      step();
      check_val("lu_issue_valid", id_valid, 1'b1);
      check_val("lu_issue_waddr", id_waddr, 5'd4);

      // beq taken with MEM-forwarded $1 and regfile $2.
      @(negedge clk); idle_inputs(); wb_we = 1; wb_waddr = 5'd2; wb_wdata = 32'd7; step();
      @(negedge clk); idle_inputs(); if_inst = i_type(6'h04, 5'd1, 5'd2, 16'd4); if_pc = 32'h100; if_pc_plus4 = 32'h104; step();
      @(negedge clk); idle_inputs(); mem_wreg = 1; mem_waddr = 5'd1; mem_result = 32'd7;
      #1 check_val("beq_npc", npc, 32'h114);
      check_val("beq_flush", Flush, 1'b1);
      step();

      // jal.
      @(negedge clk); idle_inputs(); if_inst = {6'h03, 26'h10}; if_pc = 32'h0040_0010; if_pc_plus4 = 32'h0040_0014; step();
      @(negedge clk); idle_inputs();
      #1 check_val("jal_npc", npc, 32'h0000_0040);
      check_val("jal_flush", Flush, 1'b1);
      step();
      check_val("jal_waddr", id_waddr, 5'd31);
      check_val("jal_imm", id_imm_ext, 32'h0040_0014);
      check_val("jal_op", id_alu_op, 3'd5);

      // bne with an EX producer of $1: stall, then redirect once resolved.
      @(negedge clk); idle_inputs(); if_inst = i_type(6'h05, 5'd1, 5'd0, 16'd8); if_pc = 32'h300; if_pc_plus4 = 32'h304; step();
      @(negedge clk); idle_inputs(); ex_wreg = 1; ex_waddr = 5'd1;
      #1 check_val("bh_stall", pc_stall_en, 1'b1);
      check_val("bh_no_flush", Flush, 1'b0);
      check_val("bh_no_npc", npc, 32'hffff_ffff);
      step();
      @(negedge clk); idle_inputs(); mem_wreg = 1; mem_waddr = 5'd1; mem_result = 32'd5;
      #1 check_val("bh_resolved_npc", npc, 32'h324);
      step();

      // Randomized traffic.
      repeat (800) begin
         @(negedge clk); random_inputs(); step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
